// File: rtl/exe_if.sv
// ID/EX -> EX bundle and EX -> EX/MEM results.
//   master : decode side / testbench; drives the E-stage fields, observes redirect and M-stage fields
//   slave  : execute stage; consumes E-stage fields, drives PCSrcE/PCTargetE and the M-stage fields
interface exe_if;
   logic        RegWriteE, MemWriteE, JumpE, JalrE, BranchE, ALUSrcE, Op5E;
   logic [1:0]  ResultSrcE, StoreE;
   logic [2:0]  LoadE, funct3E;
   logic [3:0]  ALUControlE;
   logic [4:0]  RDE;
   logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E, upimmE;

   logic        PCSrcE;
   logic [31:0] PCTargetE;

   logic        RegWriteM, MemWriteM;
   logic [1:0]  ResultSrcM, StoreM;
   logic [2:0]  LoadM;
   logic [4:0]  RDM;
   logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

   modport master (
      output RegWriteE, MemWriteE, JumpE, JalrE, BranchE, ALUSrcE, Op5E,
             ResultSrcE, StoreE, LoadE, funct3E, ALUControlE, RDE,
             RD1E, RD2E, ImmExtE, PCE, PCPlus4E, upimmE,
      input  PCSrcE, PCTargetE,
             RegWriteM, MemWriteM, ResultSrcM, StoreM, LoadM, RDM,
             ALUResultM, WriteDataM, PCPlus4M
   );

   modport slave (
      input  RegWriteE, MemWriteE, JumpE, JalrE, BranchE, ALUSrcE, Op5E,
             ResultSrcE, StoreE, LoadE, funct3E, ALUControlE, RDE,
             RD1E, RD2E, ImmExtE, PCE, PCPlus4E, upimmE,
      output PCSrcE, PCTargetE,
             RegWriteM, MemWriteM, ResultSrcM, StoreM, LoadM, RDM,
             ALUResultM, WriteDataM, PCPlus4M
   );
endinterface

// File: rtl/exe.sv
// Execute stage of the five-stage RISC-V pipeline.
//   clk   : pipeline clock, rising edge
//   reset : asynchronous active-high, clears the EX/MEM register
//   bus   : exe_if.slave; ID/EX fields in, same-cycle redirect (PCSrcE/PCTargetE)
//           out, EX/MEM register outputs (*M) one cycle later
module exe (
   input  logic clk,
   input  logic reset,
   exe_if.slave bus
);

   logic [31:0] src_b;
   logic [31:0] alu_out;
   logic [31:0] alu_result_d;
   logic        br_cond;

   logic        reg_write_q, mem_write_q;
   logic [1:0]  result_src_q, store_q;
   logic [2:0]  load_q;
   logic [4:0]  rd_q;
   logic [31:0] alu_result_q, write_data_q, pc_plus4_q;

   assign src_b = bus.ALUSrcE ? bus.ImmExtE : bus.RD2E;

   always_comb begin
      alu_out = 32'd0;
      unique case (bus.ALUControlE)
         4'b0000: alu_out = bus.RD1E + src_b;
         4'b0001: alu_out = bus.RD1E - src_b;
         4'b0010: alu_out = bus.RD1E & src_b;
         4'b0011: alu_out = bus.RD1E | src_b;
         4'b0100: alu_out = bus.RD1E ^ src_b;
         4'b0101: alu_out = {31'd0, $signed(bus.RD1E) < $signed(src_b)};
         4'b0110: alu_out = {31'd0, bus.RD1E < src_b};
         4'b0111: alu_out = bus.RD1E << src_b[4:0];
         4'b1000: alu_out = bus.RD1E >> src_b[4:0];
         4'b1001: alu_out = $signed(bus.RD1E) >>> src_b[4:0];
         default: alu_out = 32'd0;
      endcase
   end

   // ResultSrc 11 marks lui/auipc; Op5 distinguishes them
   always_comb begin
      alu_result_d = alu_out;
      if (bus.ResultSrcE == 2'b11)
         alu_result_d = bus.Op5E ? bus.upimmE : bus.PCE + bus.upimmE;
   end

   // Branch compares register operands, never the immediate-muxed SrcB
   always_comb begin
      br_cond = 1'b0;
      unique case (bus.funct3E)
         3'b000:  br_cond = (bus.RD1E == bus.RD2E);
         3'b001:  br_cond = (bus.RD1E != bus.RD2E);
         3'b100:  br_cond = ($signed(bus.RD1E) <  $signed(bus.RD2E));
         3'b101:  br_cond = ($signed(bus.RD1E) >= $signed(bus.RD2E));
         3'b110:  br_cond = (bus.RD1E <  bus.RD2E);
         3'b111:  br_cond = (bus.RD1E >= bus.RD2E);
         default: br_cond = 1'b0;
      endcase
   end

   assign bus.PCSrcE    = bus.JumpE | bus.JalrE | (bus.BranchE & br_cond);
   assign bus.PCTargetE = bus.JalrE ? ((bus.RD1E + bus.ImmExtE) & 32'hFFFF_FFFE)
                                    : (bus.PCE + bus.ImmExtE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reg_write_q  <= 1'b0;
         mem_write_q  <= 1'b0;
         result_src_q <= 2'd0;
         store_q      <= 2'd0;
         load_q       <= 3'd0;
         rd_q         <= 5'd0;
         alu_result_q <= 32'd0;
         write_data_q <= 32'd0;
         pc_plus4_q   <= 32'd0;
      end else begin
         reg_write_q  <= bus.RegWriteE;
         mem_write_q  <= bus.MemWriteE;
         result_src_q <= bus.ResultSrcE;
         store_q      <= bus.StoreE;
         load_q       <= bus.LoadE;
         rd_q         <= bus.RDE;
         alu_result_q <= alu_result_d;
         write_data_q <= bus.RD2E;
         pc_plus4_q   <= bus.PCPlus4E;
      end
   end

   assign bus.RegWriteM  = reg_write_q;
   assign bus.MemWriteM  = mem_write_q;
   assign bus.ResultSrcM = result_src_q;
   assign bus.StoreM     = store_q;
   assign bus.LoadM      = load_q;
   assign bus.RDM        = rd_q;
   assign bus.ALUResultM = alu_result_q;
   assign bus.WriteDataM = write_data_q;
   assign bus.PCPlus4M   = pc_plus4_q;

endmodule

// File: tb/tb_exe.sv
module tb_exe;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   exe_if bus ();
   exe dut (.clk(clk), .reset(reset), .bus(bus));

   int errs = 0;
   int checks = 0;

   logic        e_rw, e_mw;
   logic [1:0]  e_rs, e_st;
   logic [2:0]  e_ld;
   logic [4:0]  e_rd;
   logic [31:0] e_alu, e_wd, e_pc4;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
      logic [63:0] ext;
      int unsigned sh;
      sh = b % 32;
      case (op)
         0: return a + b;
         1: return a + (~b + 1);
         2: return a & b;
         3: return a | b;
         4: return a ^ b;
         5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         6: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd0 + (int'(a ^ 32'h8000_0000) < int'(b ^ 32'h8000_0000)) : 32'd0 + (int'(a ^ 32'h8000_0000) < int'(b ^ 32'h8000_0000));
         7: return a * (32'd1 << sh);
         8: return a / (32'd1 << sh);
         9: begin ext = {{32{a[31]}}, a}; ext = ext >> sh; return ext[31:0]; end
         default: return 32'd0;
      endcase
   endfunction

   function automatic bit m_taken();
      int sa, sb;
      sa = int'(bus.RD1E); sb = int'(bus.RD2E);
      case (bus.funct3E)
         0: return bus.RD1E == bus.RD2E;
         1: return bus.RD1E != bus.RD2E;
         4: return sa < sb;
         5: return !(sa < sb);
         6: return longint'({32'd0, bus.RD1E}) < longint'({32'd0, bus.RD2E});
         7: return !(longint'({32'd0, bus.RD1E}) < longint'({32'd0, bus.RD2E}));
         default: return 1'b0;
      endcase
   endfunction

   // Checks same-cycle redirect and records what the EX/MEM register must hold next
   task automatic model_and_check_comb();
      logic [31:0] b, tgt;
      bit take;
      b = bus.ALUSrcE ? bus.ImmExtE : bus.RD2E;
      take = bus.JumpE || bus.JalrE || (bus.BranchE && m_taken());
      if (bus.JalrE) tgt = (bus.RD1E + bus.ImmExtE) & ~32'd1;
      else           tgt = bus.PCE + bus.ImmExtE;
      chk("pcsrc", {31'd0, bus.PCSrcE}, {31'd0, take});
      chk("pctarget", bus.PCTargetE, tgt);
      e_rw = bus.RegWriteE; e_mw = bus.MemWriteE; e_rs = bus.ResultSrcE;
      e_st = bus.StoreE; e_ld = bus.LoadE; e_rd = bus.RDE;
      e_wd = bus.RD2E; e_pc4 = bus.PCPlus4E;
      if (bus.ResultSrcE == 2'b11) e_alu = bus.Op5E ? bus.upimmE : bus.PCE + bus.upimmE;
      else                         e_alu = m_alu(bus.ALUControlE, bus.RD1E, b);
   endtask

   task automatic check_m();
      chk("regwrite_m", {31'd0, bus.RegWriteM}, {31'd0, e_rw});
      chk("memwrite_m", {31'd0, bus.MemWriteM}, {31'd0, e_mw});
      chk("resultsrc_m", {30'd0, bus.ResultSrcM}, {30'd0, e_rs});
      chk("store_m", {30'd0, bus.StoreM}, {30'd0, e_st});
      chk("load_m", {29'd0, bus.LoadM}, {29'd0, e_ld});
      chk("rd_m", {27'd0, bus.RDM}, {27'd0, e_rd});
      chk("aluresult_m", bus.ALUResultM, e_alu);
      chk("writedata_m", bus.WriteDataM, e_wd);
      chk("pcplus4_m", bus.PCPlus4M, e_pc4);
   endtask

   task automatic check_m_zero();
      chk("rst_regwrite", {31'd0, bus.RegWriteM}, 32'd0);
      chk("rst_memwrite", {31'd0, bus.MemWriteM}, 32'd0);
      chk("rst_resultsrc", {30'd0, bus.ResultSrcM}, 32'd0);
      chk("rst_store", {30'd0, bus.StoreM}, 32'd0);
      chk("rst_load", {29'd0, bus.LoadM}, 32'd0);
      chk("rst_rd", {27'd0, bus.RDM}, 32'd0);
      chk("rst_aluresult", bus.ALUResultM, 32'd0);
      chk("rst_writedata", bus.WriteDataM, 32'd0);
      chk("rst_pcplus4", bus.PCPlus4M, 32'd0);
   endtask

   // Called just after a rising edge: inputs settle, comb check, then next edge and M check
   task automatic cycle();
      #1;
      model_and_check_comb();
      @(posedge clk);
      #1;
      check_m();
   endtask

   task automatic clear_in();
      bus.RegWriteE = 0; bus.MemWriteE = 0; bus.JumpE = 0; bus.JalrE = 0;
      bus.BranchE = 0; bus.ALUSrcE = 0; bus.Op5E = 0; bus.ResultSrcE = 0;
      bus.StoreE = 0; bus.LoadE = 0; bus.funct3E = 0; bus.ALUControlE = 0;
      bus.RDE = 0; bus.RD1E = 0; bus.RD2E = 0; bus.ImmExtE = 0; bus.PCE = 0;
      bus.PCPlus4E = 0; bus.upimmE = 0;
   endtask

   task automatic rand_in();
      bus.RegWriteE = 1'($urandom); bus.MemWriteE = 1'($urandom);
      bus.JumpE = ($urandom_range(0, 5) == 0); bus.JalrE = ($urandom_range(0, 5) == 0);
      bus.BranchE = 1'($urandom); bus.ALUSrcE = 1'($urandom); bus.Op5E = 1'($urandom);
      bus.ResultSrcE = 2'($urandom); bus.StoreE = 2'($urandom); bus.LoadE = 3'($urandom);
      bus.funct3E = 3'($urandom); bus.ALUControlE = 4'($urandom); bus.RDE = 5'($urandom);
      bus.RD1E = $urandom; bus.RD2E = $urandom; bus.ImmExtE = $urandom;
      bus.PCE = $urandom; bus.PCPlus4E = bus.PCE + 4; bus.upimmE = $urandom & 32'hFFFF_F000;
      if ($urandom_range(0, 3) == 0) bus.RD2E = bus.RD1E;
      if ($urandom_range(0, 3) == 0) bus.RD1E = {1'b1, 31'($urandom_range(0, 7))};
   endtask

   initial begin
      clear_in();
      reset = 1'b1;
      #1;
      check_m_zero();
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);

      // ALU wrap on add with immediate
      clear_in();
      bus.RD1E = 32'hFFFF_FFFF; bus.ImmExtE = 1; bus.ALUSrcE = 1; bus.RDE = 5'd7; bus.RegWriteE = 1;
      cycle();
      chk("add_wrap", bus.ALUResultM, 32'h0000_0000);

      clear_in();
      bus.RD1E = 32'h8000_0000; bus.RD2E = 4; bus.ALUControlE = 4'b1001;
      cycle();
      chk("sra", bus.ALUResultM, 32'hF800_0000);

      clear_in();
      bus.RD1E = 32'hFFFF_FFFF; bus.RD2E = 1; bus.ALUControlE = 4'b0101;
      cycle();
      chk("slt", bus.ALUResultM, 32'd1);
      bus.ALUControlE = 4'b0110;
      cycle();
      chk("sltu", bus.ALUResultM, 32'd0);

      // Branch signed vs unsigned on same operands
      clear_in();
      bus.BranchE = 1; bus.funct3E = 3'b100; bus.RD1E = -32'sd3; bus.RD2E = 2;
      bus.PCE = 32'h100; bus.ImmExtE = 32'hFFFF_FFF0;
      #1;
      chk("blt_src", {31'd0, bus.PCSrcE}, 32'd1);
      chk("blt_tgt", bus.PCTargetE, 32'h0000_00F0);
      cycle();
      bus.funct3E = 3'b110;
      #1;
      chk("bltu_src", {31'd0, bus.PCSrcE}, 32'd0);
      cycle();

      // Jalr, also with JumpE set
      clear_in();
      bus.JalrE = 1; bus.RD1E = 32'h1003; bus.ImmExtE = 32'h10; bus.PCE = 32'h400;
      bus.PCPlus4E = 32'h404; bus.RegWriteE = 1; bus.RDE = 5'd1;
      #1;
      chk("jalr_tgt", bus.PCTargetE, 32'h1012);
      chk("jalr_src", {31'd0, bus.PCSrcE}, 32'd1);
      cycle();
      chk("jalr_pc4", bus.PCPlus4M, 32'h404);
      bus.JumpE = 1;
      #1;
      chk("jal_jalr_tgt", bus.PCTargetE, 32'h1012);
      cycle();

      // Upper immediate
      clear_in();
      bus.ResultSrcE = 2'b11; bus.upimmE = 32'h1234_5000; bus.PCE = 32'h2000; bus.Op5E = 1;
      bus.RD1E = 32'h55; bus.RD2E = 32'h66;
      cycle();
      chk("lui", bus.ALUResultM, 32'h1234_5000);
      bus.Op5E = 0;
      cycle();
      chk("auipc", bus.ALUResultM, 32'h1234_7000);

      // Reset mid-instruction: M cleared without a clock edge
      rand_in();
      bus.RegWriteE = 1; bus.RD2E = 32'hDEAD_BEEF; bus.RDE = 5'd9;
      cycle();
      rand_in();
      #2;
      reset = 1'b1;
      #1;
      check_m_zero();
      model_and_check_comb();
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check_m();

      // Back-to-back randomized instructions
      for (int i = 0; i < 60; i++) begin
         rand_in();
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/exe.md
# exe

Execute stage of the five-stage RISC-V pipeline: the consumer of the ID/EX register driven by the decode stage. Computes ALU and upper-immediate results, resolves branches and jumps, and returns the redirect target to fetch in the same cycle. Registers the memory-stage control and data into the EX/MEM pipeline register.

## Interface
- No parameters; datapath is fixed at 32 bits, register index at 5 bits.
- clk  input  1  pipeline clock, all registers rise-edge triggered
- reset  input  1  asynchronous, active-high; clears the EX/MEM register
- RegWriteE, MemWriteE, JumpE, JalrE, BranchE, ALUSrcE, Op5E  input  1 each  ID/EX control
- ResultSrcE, StoreE  input  2 each  ID/EX control
- LoadE, funct3E  input  3 each  load type; branch condition select
- ALUControlE  input  4  ALU operation
- RDE  input  5  destination register
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E, upimmE  input  32 each  ID/EX operands
- PCSrcE  output  1  combinational: redirect fetch this cycle
- PCTargetE  output  32  combinational redirect address
- RegWriteM, MemWriteM  output  1 each  registered control
- ResultSrcM, StoreM  output  2 each  registered control
- LoadM  output  3  registered load type
- RDM  output  5  registered destination
- ALUResultM, WriteDataM, PCPlus4M  output  32 each  registered data

## Operation
- SrcA = RD1E; SrcB = ALUSrcE ? ImmExtE : RD2E.
- ALUControlE: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt (signed), 0110 sltu, 0111 sll, 1000 srl, 1001 sra; 1010-1111 produce 0. Shifts use SrcB[4:0] only. Add/sub wrap modulo 2^32, no overflow flag.
- ExResult: ResultSrcE == 11 selects upper-immediate path: Op5E=1 (lui) -> upimmE; Op5E=0 (auipc) -> PCE + upimmE. Otherwise ExResult = ALU output.
- Branch condition on RD1E vs RD2E (never SrcB), by funct3E: 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 lt unsigned, 111 ge unsigned; 010/011 never taken.
- PCSrcE = JumpE | JalrE | (BranchE & condition).
- PCTargetE = JalrE ? ((RD1E + ImmExtE) & 32'hFFFFFFFE) : (PCE + ImmExtE). Driven every cycle regardless of PCSrcE.
- JalrE and JumpE both set: jalr target wins.
- WriteDataM captures RD2E unmodified (store byte/half alignment is done in memory stage).
- Control fields RegWrite, MemWrite, ResultSrc, Store, Load, RD and PCPlus4 pass through unchanged.

## Timing
- PCSrcE, PCTargetE: zero latency, purely combinational from ID/EX inputs.
- EX/MEM outputs: one-cycle latency; values present on inputs before edge N appear after edge N.
- No stall or flush inputs; register loads every cycle when reset is low.
- Reset (any time, including mid-instruction): all M-stage outputs to 0 immediately, without waiting for clk; an in-flight instruction is discarded. PCSrcE/PCTargetE follow inputs during reset (zero inputs from a reset ID/EX register give PCSrcE=0, PCTargetE=0).
- First edge after reset deasserts captures current inputs normally.

## Test plan
- Reset: drive nonzero inputs, assert reset between edges -> all M outputs 0 at once; release -> next edge ALUResultM follows inputs.
- ALU: RD1E=0xFFFFFFFF, ImmExtE=1, ALUSrcE=1, ALUControlE=0000 -> ALUResultM=0x00000000 one edge later; RD1E=0x80000000, RD2E=4, ALUControlE=1001 -> 0xF8000000; 0101 with 0xFFFFFFFF vs 1 -> 1, 0110 -> 0.
- Branch: BranchE=1, funct3E=100, RD1E=-3, RD2E=2, PCE=0x100, ImmExtE=0xFFFFFFF0 -> PCSrcE=1, PCTargetE=0xF0 same cycle; funct3E=110 same operands -> PCSrcE=0.
- Jalr: JalrE=1, RD1E=0x1003, ImmExtE=0x10 -> PCTargetE=0x1012, PCSrcE=1; PCPlus4M equals PCPlus4E after edge.
- Upper immediate: ResultSrcE=11, upimmE=0x12345000, PCE=0x2000: Op5E=1 -> ALUResultM=0x12345000; Op5E=0 -> 0x12347000.
- Back-to-back: three different instructions on consecutive cycles -> M outputs reproduce each exactly one cycle later with no mixing of fields.
